seg_scan_decoder: RTL

Receive-side counterpart of the stopwatch's multiplexed 7-segment display driver. It watches the scanned segment bus and digit-enable lines, waits for each digit dwell to settle, and decodes each hex glyph back to a 4-bit value. It also reports frame completion and flags malformed scan activity. It is used as a loopback checker and on-board monitor, attached in parallel to the display pins.

---
 rtl/seg_scan_decoder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed 7-segment scan bus and decodes each settled digit
// dwell back to its hex value, with frame completion and sticky fault reporting.
module seg_scan_decoder #(
    parameter int unsigned SETTLE         = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          EN_ACTIVE_LOW  = 1'b1
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [7:0] DIGIT7SEG,
    input  logic [3:0] ENABLE7SEG,
    output logic [3:0] DIGIT0,
    output logic [3:0] DIGIT1,
    output logic [3:0] DIGIT2,
    output logic [3:0] DIGIT3,
    output logic [3:0] DP,
    output logic       VALID,
    output logic       FRAME_TICK,
    output logic       ERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLING,
        S_SAMPLED
    } state_t;

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    logic [7:0] seg_norm;
    logic [3:0] en_norm;
    logic [7:0] seg_s1_q, seg_s2_q;
    logic [3:0] en_s1_q, en_s2_q;

    state_t     state_q, state_d;
    logic [3:0] en_q, en_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       sample;
    logic       mh_err;
    logic       en_onehot;
    logic       en_multi;

    logic [3:0][3:0] digit_q, digit_d;
    logic [3:0]      dp_q, dp_d;
    logic [3:0]      seen_q, seen_d;
    logic            valid_q, valid_d;
    logic            frame_q, frame_d;
    logic            err_q, err_d;
    logic [4:0]      dec;
    logic            good;
    logic            bad;

    // Normalizing ahead of the synchronizer lets reset clear it to "blank".
    assign seg_norm = DIGIT7SEG ^ {8{SEG_ACTIVE_LOW}};
    assign en_norm  = ENABLE7SEG ^ {4{EN_ACTIVE_LOW}};

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            en_s1_q  <= '0;
            en_s2_q  <= '0;
        end else begin
            seg_s1_q <= seg_norm;
            seg_s2_q <= seg_s1_q;
            en_s1_q  <= en_norm;
            en_s2_q  <= en_s1_q;
        end
    end

    assign en_onehot = $onehot(en_s2_q);
    assign en_multi  = (en_s2_q != 4'b0000) && !en_onehot;
    assign cnt_inc   = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        cnt_d   = cnt_q;
        sample  = 1'b0;
        mh_err  = 1'b0;
        unique case (1'b1)
            en_multi: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                mh_err  = 1'b1;
            end
            (state_q == S_SETTLING) && (en_s2_q == en_q): begin
                cnt_d = cnt_inc;
                if (cnt_inc == SETTLE_C) begin
                    sample  = 1'b1;
                    state_d = S_SAMPLED;
                end
            end
            (state_q == S_SAMPLED) && (en_s2_q == en_q): begin
                cnt_d = cnt_q;
            end
            default: begin
                // IDLE, or any change of enable away from the held dwell.
                if (en_onehot) begin
                    en_d    = en_s2_q;
                    cnt_d   = 8'd1;
                    state_d = S_SETTLING;
                end else begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            en_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
        end
    end

    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7D:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h6F:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h7C:   r = 5'h1B;
            7'h39:   r = 5'h1C;
            7'h5E:   r = 5'h1D;
            7'h79:   r = 5'h1E;
            7'h71:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    assign dec  = decode(seg_s2_q[6:0]);
    assign good = sample && dec[4];
    assign bad  = sample && !dec[4];

    always_comb begin
        digit_d = digit_q;
        dp_d    = dp_q;
        for (int i = 0; i < 4; i++) begin
            if (good && en_q[i]) begin
                digit_d[i] = dec[3:0];
                dp_d[i]    = seg_s2_q[7];
            end
        end
        // Frame clear happens first so a coincident sample survives it.
        seen_d  = (seen_q == 4'hF) ? 4'h0 : seen_q;
        seen_d  = seen_d | (good ? en_q : 4'h0);
        frame_d = (seen_q == 4'hF);
        valid_d = valid_q | frame_d;
        err_d   = err_q | mh_err | bad;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            digit_q <= '0;
            dp_q    <= '0;
            seen_q  <= '0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            digit_q <= digit_d;
            dp_q    <= dp_d;
            seen_q  <= seen_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign DIGIT0     = digit_q[0];
    assign DIGIT1     = digit_q[1];
    assign DIGIT2     = digit_q[2];
    assign DIGIT3     = digit_q[3];
    assign DP         = dp_q;
    assign VALID      = valid_q;
    assign FRAME_TICK = frame_q;
    assign ERR        = err_q;

endmodule
